// File: rtl/tinyqv_lsu_if.sv
// Byte-wide req/ack memory bus between the load/store unit and memory.
//   bus_req   : beat request, held until bus_ack
//   bus_we    : 1 = write beat
//   bus_addr  : beat byte address
//   bus_wdata : write byte
//   bus_ack   : beat accepted/completed, bus_rdata valid for reads
//   bus_rdata : read byte
// master = load/store unit, slave = memory.
interface tinyqv_lsu_if #(
  parameter int unsigned ADDR_BITS = 28
);
  logic                 bus_req;
  logic                 bus_we;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [7:0]           bus_wdata;
  logic                 bus_ack;
  logic [7:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/tinyqv_lsu.sv
// Load/store unit for tinyqv_core. Captures a core memory op on mem_start,
// runs it as 1/2/4 little-endian byte beats on the req/ack bus and returns
// the raw assembled load word with a one-cycle ready pulse.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   mem_start        : first cycle of a load/store instruction
//   is_load/is_store : direction qualifiers for mem_start (both = load)
//   mem_op[1:0]      : size 00 byte, 01 half, 1x word
//   addr_in/wdata_in : byte address and store data
//   load_data        : assembled load word, valid with load_data_ready
//   load_data_ready  : one-cycle pulse when a load finishes
//   busy             : transfer on the bus in progress
//   err              : one-cycle pulse on misalignment or bus timeout
//   bus              : byte-wide memory bus (master side)
module tinyqv_lsu #(
  parameter int unsigned ADDR_BITS = 28,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mem_start,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           mem_op,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [31:0]          wdata_in,
  output logic [31:0]          load_data,
  output logic                 load_data_ready,
  output logic                 busy,
  output logic                 err,
  tinyqv_lsu_if.master         bus
);

  localparam int unsigned WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_last;
  logic [1:0]            r_beat;
  logic                  r_load;
  logic                  r_fail;
  logic [WAIT_W-1:0]     r_wait;
  logic [31:0]           r_load_data;

  logic                  w_accept;
  logic                  w_misal;
  logic [1:0]            w_size;
  logic [1:0]            w_last_idx;
  logic                  w_last_beat;
  logic                  w_timeout;
  logic                  w_unused_op;

  assign w_unused_op = mem_op[2];
  assign w_size      = mem_op[1:0];
  // Accept is allowed in RESP so a back-to-back op starts without an idle cycle.
  assign w_accept    = mem_start && (is_load || is_store) && (r_state != XFER);
  assign w_misal     = (w_size == 2'b01) ? addr_in[0]
                     : (w_size[1]        ? (|addr_in[1:0]) : 1'b0);
  assign w_last_idx  = w_size[1] ? 2'd3 : {1'b0, w_size[0]};
  assign w_last_beat = (r_beat == r_last);
  // Fires in the TIMEOUT-th consecutive unacknowledged request cycle of a beat.
  assign w_timeout   = (TIMEOUT != 0) && !bus.bus_ack && (r_wait == WAIT_W'(TO_LAST));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_misal ? RESP : XFER;
      XFER:    if ((bus.bus_ack && w_last_beat) || w_timeout) w_next = RESP;
      RESP:    if (w_accept) w_next = w_misal ? RESP : XFER;
               else          w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last      <= '0;
      r_beat      <= '0;
      r_load      <= 1'b0;
      r_fail      <= 1'b0;
      r_wait      <= '0;
      r_load_data <= '0;
    end else if (w_accept) begin
      r_addr      <= addr_in;
      r_wdata     <= wdata_in;
      r_last      <= w_last_idx;
      r_beat      <= '0;
      r_load      <= is_load;
      r_fail      <= w_misal;
      r_wait      <= '0;
      r_load_data <= '0;
    end else if (r_state == XFER) begin
      if (bus.bus_ack) begin
        if (r_load) r_load_data[{r_beat, 3'b000} +: 8] <= bus.bus_rdata;
        r_beat <= r_beat + 2'd1;
        r_wait <= '0;
      end else if (w_timeout) begin
        // A timed-out load reports zero, discarding any bytes already read.
        r_fail      <= 1'b1;
        r_load_data <= '0;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign busy            = (r_state == XFER);
  assign load_data_ready = (r_state == RESP) && r_load;
  assign err             = (r_state == RESP) && r_fail;
  assign load_data       = r_load_data;

  assign bus.bus_req   = busy;
  assign bus.bus_we    = busy && !r_load;
  assign bus.bus_addr  = busy ? (r_addr + ADDR_BITS'(r_beat)) : '0;
  assign bus.bus_wdata = busy ? r_wdata[{r_beat, 3'b000} +: 8] : '0;

endmodule

// File: tb/tb_tinyqv_lsu.sv
// Scoreboard bench for tinyqv_lsu: stimulus pushes expected bus beats and
// responses, a monitor pops and compares them as the DUT presents them.
module tb_tinyqv_lsu;
  localparam int unsigned AB = 28;

  typedef struct {
    logic [AB-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
  } beat_t;

  typedef struct {
    logic        ready;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          mem_start = 1'b0;
  logic          is_load = 1'b0;
  logic          is_store = 1'b0;
  logic [2:0]    mem_op = '0;
  logic [AB-1:0] addr_in = '0;
  logic [31:0]   wdata_in = '0;
  logic [31:0]   load_data;
  logic          load_data_ready;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay = 0;
  logic [7:0] rd_q[$];
  beat_t exp_beats[$];
  resp_t exp_resps[$];

  tinyqv_lsu_if #(.ADDR_BITS(AB)) bus_if ();

  tinyqv_lsu #(.ADDR_BITS(AB), .TIMEOUT(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_start       (mem_start),
    .is_load         (is_load),
    .is_store        (is_store),
    .mem_op          (mem_op),
    .addr_in         (addr_in),
    .wdata_in        (wdata_in),
    .load_data       (load_data),
    .load_data_ready (load_data_ready),
    .busy            (busy),
    .err             (err),
    .bus             (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [AB-1:0] a, input logic we, input logic [7:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.wdata = d;
    return b;
  endfunction

  function automatic resp_t mk_resp(input logic rdy, input logic e, input logic [31:0] d);
    resp_t r;
    r.ready = rdy; r.err = e; r.data = d;
    return r;
  endfunction

  // Memory model: ack after ack_delay waiting cycles per beat (-1 = never).
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.bus_req) begin
        if (wait_cnt == ack_delay) begin
          bus_if.bus_ack = 1'b1;
          if (rd_q.size() > 0) bus_if.bus_rdata = rd_q.pop_front();
          else                 bus_if.bus_rdata = 8'h00;
          wait_cnt = 0;
        end else begin
          bus_if.bus_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus_if.bus_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare every completed beat and every response pulse.
  initial begin
    beat_t b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req && bus_if.bus_ack) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h we %0b, required none", bus_if.bus_addr, bus_if.bus_we);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_addr", bus_if.bus_addr, b.addr);
          chk("beat_we", bus_if.bus_we, b.we);
          if (b.we) chk("beat_wdata", bus_if.bus_wdata, b.wdata);
        end
      end
      if (load_data_ready || err) begin
        if (exp_resps.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got ready %0b err %0b data 0x%0h, required none", load_data_ready, err, load_data);
        end else begin
          r = exp_resps.pop_front();
          chk("resp_ready", load_data_ready, r.ready);
          chk("resp_err", err, r.err);
          if (r.ready) chk("resp_data", load_data, r.data);
        end
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                       input logic [AB-1:0] a, input logic [31:0] d);
    mem_start = 1'b1; is_load = ld; is_store = st; mem_op = op; addr_in = a; wdata_in = d;
    @(posedge clk);
    #1;
    mem_start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  // Returns at the first negedge with busy low (the RESP cycle after a transfer).
  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic count_cycles(input int n, output int n_busy, output int n_req);
    n_busy = 0; n_req = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (bus_if.bus_req) n_req++;
    end
  endtask

  initial begin
    int nb, nr;
    logic found;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_if.bus_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", load_data_ready, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // LW 0x100, two wait cycles per beat
    ack_delay = 2;
    rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) exp_beats.push_back(mk_beat(AB'(32'h100 + i), 1'b0, 8'h00));
    exp_resps.push_back(mk_resp(1'b1, 1'b0, 32'h44332211));
    issue(1'b1, 1'b0, 3'b010, 28'h100, 32'h0);
    wait_idle("lw_idle");
    chk("lw_ready_after_last_ack", load_data_ready, 1'b1);
    @(negedge clk);

    // LH misaligned: clears the previous load word, no bus traffic
    exp_resps.push_back(mk_resp(1'b1, 1'b1, 32'h0));
    issue(1'b1, 1'b0, 3'b001, 28'h101, 32'h0);
    count_cycles(5, nb, nr);
    chk("lh_misal_no_req", nr, 0);

    // SB 0x203, immediate ack
    ack_delay = 0;
    exp_beats.push_back(mk_beat(28'h203, 1'b1, 8'hDD));
    issue(1'b0, 1'b1, 3'b000, 28'h203, 32'hAABBCCDD);
    count_cycles(6, nb, nr);
    chk("sb_busy_cycles", nb, 1);

    // SH 0x1FE
    exp_beats.push_back(mk_beat(28'h1FE, 1'b1, 8'hEF));
    exp_beats.push_back(mk_beat(28'h1FF, 1'b1, 8'hBE));
    issue(1'b0, 1'b1, 3'b001, 28'h1FE, 32'h0000BEEF);
    wait_idle("sh_idle");
    @(negedge clk);

    // LB 0x40 with no ack: timeout after 4 request cycles
    ack_delay = -1;
    exp_resps.push_back(mk_resp(1'b1, 1'b1, 32'h0));
    issue(1'b1, 1'b0, 3'b000, 28'h40, 32'h0);
    count_cycles(10, nb, nr);
    chk("timeout_req_cycles", nr, 4);
    chk("timeout_busy_after", busy, 1'b0);

    // LW with reset asserted during beat 2
    ack_delay = 2;
    rd_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_beats.push_back(mk_beat(28'h100, 1'b0, 8'h00));
    issue(1'b1, 1'b0, 3'b010, 28'h100, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.bus_req && bus_if.bus_addr == 28'h101) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid_reach_beat2", found, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_req_drop", bus_if.bus_req, 1'b0);
    chk("rst_mid_busy_drop", busy, 1'b0);
    rd_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    count_cycles(4, nb, nr);
    chk("rst_mid_quiet_busy", nb, 0);
    ack_delay = 1;
    rd_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) exp_beats.push_back(mk_beat(AB'(32'h100 + i), 1'b0, 8'h00));
    exp_resps.push_back(mk_resp(1'b1, 1'b0, 32'h04030201));
    issue(1'b1, 1'b0, 3'b010, 28'h100, 32'h0);
    wait_idle("lw_after_rst_idle");
    @(negedge clk);

    // Size 11 as word, load+store as load, mem_start during XFER ignored
    ack_delay = 0;
    rd_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 4; i++) exp_beats.push_back(mk_beat(AB'(32'h30 + i), 1'b0, 8'h00));
    exp_resps.push_back(mk_resp(1'b1, 1'b0, 32'hC4C3C2C1));
    issue(1'b1, 1'b1, 3'b111, 28'h30, 32'hFFFFFFFF);
    issue(1'b0, 1'b1, 3'b000, 28'h60, 32'h0);
    wait_idle("w11_idle");
    @(negedge clk);

    // mem_start without direction is ignored
    issue(1'b0, 1'b0, 3'b010, 28'h50, 32'h0);
    count_cycles(4, nb, nr);
    chk("nodir_ignored", nb, 0);

    // SW misaligned: err only
    exp_resps.push_back(mk_resp(1'b0, 1'b1, 32'h0));
    issue(1'b0, 1'b1, 3'b010, 28'h102, 32'h12345678);
    count_cycles(3, nb, nr);
    chk("sw_misal_no_req", nr, 0);

    // Back-to-back LB then SW accepted in the RESP cycle
    rd_q = '{8'h5A};
    exp_beats.push_back(mk_beat(28'h10, 1'b0, 8'h00));
    exp_resps.push_back(mk_resp(1'b1, 1'b0, 32'h0000005A));
    exp_beats.push_back(mk_beat(28'h20, 1'b1, 8'h78));
    exp_beats.push_back(mk_beat(28'h21, 1'b1, 8'h56));
    exp_beats.push_back(mk_beat(28'h22, 1'b1, 8'h34));
    exp_beats.push_back(mk_beat(28'h23, 1'b1, 8'h12));
    issue(1'b1, 1'b0, 3'b000, 28'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_resp_cycle", load_data_ready, 1'b1);
    issue(1'b0, 1'b1, 3'b010, 28'h20, 32'h12345678);
    @(negedge clk);
    chk("b2b_no_gap_req", bus_if.bus_req, 1'b1);
    chk("b2b_no_gap_addr", bus_if.bus_addr, 28'h20);
    wait_idle("b2b_idle");

    for (int i = 0; i < 50; i++) begin
      if (exp_beats.size() == 0 && exp_resps.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("beats_outstanding", exp_beats.size(), 0);
    chk("resps_outstanding", exp_resps.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
